// File: rtl/keypad_pkg.sv
// keypad_pkg: key code enumeration, keypad layout map and default timing constants.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package keypad_pkg;

  localparam int DEF_SAMPLE_DIV   = 2_000_000;
  localparam int DEF_DEBOUNCE_CNT = 3;
  localparam int DEF_FIFO_DEPTH   = 4;

  typedef enum logic [3:0] {
    KEY_0    = 4'd0,
    KEY_1    = 4'd1,
    KEY_2    = 4'd2,
    KEY_3    = 4'd3,
    KEY_4    = 4'd4,
    KEY_5    = 4'd5,
    KEY_6    = 4'd6,
    KEY_7    = 4'd7,
    KEY_8    = 4'd8,
    KEY_9    = 4'd9,
    KEY_A    = 4'd10,
    KEY_B    = 4'd11,
    KEY_C    = 4'd12,
    KEY_D    = 4'd13,
    KEY_STAR = 4'd14,
    KEY_HASH = 4'd15
  } key_code_e;

  // Matrix index (row*4+col) to key code for the layout
  //   1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  function automatic key_code_e index_to_code(input logic [3:0] idx);
    key_code_e code;
    case (idx)
      4'd0:    code = KEY_1;
      4'd1:    code = KEY_2;
      4'd2:    code = KEY_3;
      4'd3:    code = KEY_A;
      4'd4:    code = KEY_4;
      4'd5:    code = KEY_5;
      4'd6:    code = KEY_6;
      4'd7:    code = KEY_B;
      4'd8:    code = KEY_7;
      4'd9:    code = KEY_8;
      4'd10:   code = KEY_9;
      4'd11:   code = KEY_C;
      4'd12:   code = KEY_STAR;
      4'd13:   code = KEY_0;
      4'd14:   code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

  // Index of the lowest set bit; 0 when the mask is empty (callers gate on mask != 0).
  function automatic logic [3:0] lowest_index(input logic [15:0] mask);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// keypad_event_fifo: small synchronous FIFO for key events, head is visible combinationally.
// Latency: a push is visible at the head the cycle after the push edge.
// Backpressure: push on full is dropped unless a pop happens in the same cycle; pop on empty is ignored.
module keypad_event_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // When full, a simultaneous pop frees the head slot, which is the one being written.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  // Storage; contents need no reset because empty gates every use of the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/keypad_key_decoder.sv
// keypad_key_decoder: debounces 4x4 keypad snapshots and queues key codes of newly pressed keys.
// Latency: accept on sample strobe S -> key_held at S+1 -> key_valid at S+2 when the queue is empty.
// Backpressure: key_ready low holds the head; events pushed into a full queue are dropped, setting sticky overflow.
// Option: define KEYPAD_RELEASE_EVENT_EN to also queue release events (key_release=1), served after presses.
module keypad_key_decoder
  import keypad_pkg::*;
#(
  parameter int SAMPLE_DIV   = DEF_SAMPLE_DIV,
  parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row0,
  input  logic [3:0]  row1,
  input  logic [3:0]  row2,
  input  logic [3:0]  row3,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [3:0]  key_code,
  output logic        key_release,
  output logic [15:0] key_held,
  output logic        overflow
);

  localparam int SW = $clog2(SAMPLE_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT);
`ifdef KEYPAD_RELEASE_EVENT_EN
  localparam int EW = 5;
`else
  localparam int EW = 4;
`endif

  logic [SW-1:0] sample_cnt;
  logic          strobe;
  logic [15:0]   raw;
  logic [15:0]   last;
  logic [15:0]   stable;
  logic [15:0]   pending;
  logic [15:0]   new_press;
  logic [15:0]   press_clr;
  logic [CW-1:0] db_cnt;
  logic          accept;
  logic          push;
  logic [3:0]    sel_idx;
  logic [EW-1:0] push_data;
  logic [EW-1:0] head;
  logic          fifo_full;
  logic          fifo_empty;

  assign raw    = {row3, row2, row1, row0};
  assign strobe = (sample_cnt == SW'(SAMPLE_DIV - 1));
  // The count saturates at DEBOUNCE_CNT-1, so a held state is re-accepted every strobe;
  // that is harmless because only bits that differ from stable create events.
  assign accept    = strobe && (raw == last) && (db_cnt >= CW'(DEBOUNCE_CNT - 2));
  assign new_press = accept ? (raw & ~stable) : 16'h0;

  // Sample divider: one strobe per full scanner pass.
  always_ff @(posedge clk) begin
    if (rst)         sample_cnt <= '0;
    else if (strobe) sample_cnt <= '0;
    else             sample_cnt <= sample_cnt + SW'(1);
  end

  // Debounce: count consecutive identical samples, restart on any change.
  always_ff @(posedge clk) begin
    if (rst) begin
      last   <= '0;
      db_cnt <= '0;
    end else if (strobe) begin
      if (raw == last) begin
        if (db_cnt != CW'(DEBOUNCE_CNT - 1)) db_cnt <= db_cnt + CW'(1);
      end else begin
        db_cnt <= '0;
        last   <= raw;
      end
    end
  end

`ifdef KEYPAD_RELEASE_EVENT_EN
  logic [15:0] rel_pending;
  logic [15:0] rel_clr;
  logic [15:0] new_rel;
  logic        serve_rel;

  assign new_rel = accept ? (~raw & stable) : 16'h0;

  // Encoder: one event per cycle, presses before releases, lowest index first.
  always_comb begin
    push      = 1'b0;
    serve_rel = 1'b0;
    sel_idx   = lowest_index(pending);
    press_clr = 16'h0;
    rel_clr   = 16'h0;
    if (pending != 16'h0) begin
      push      = 1'b1;
      press_clr = 16'h1 << sel_idx;
    end else if (rel_pending != 16'h0) begin
      push      = 1'b1;
      serve_rel = 1'b1;
      sel_idx   = lowest_index(rel_pending);
      rel_clr   = 16'h1 << sel_idx;
    end
    push_data = {serve_rel, index_to_code(sel_idx)};
  end

  // Release mask: served bits cleared, newly released keys added on accept.
  always_ff @(posedge clk) begin
    if (rst) rel_pending <= '0;
    else     rel_pending <= (rel_pending & ~rel_clr) | new_rel;
  end

  assign key_release = fifo_empty ? 1'b0 : head[4];
`else
  // Encoder: one press event per cycle, lowest index first.
  always_comb begin
    push      = 1'b0;
    sel_idx   = lowest_index(pending);
    press_clr = 16'h0;
    if (pending != 16'h0) begin
      push      = 1'b1;
      press_clr = 16'h1 << sel_idx;
    end
    push_data = index_to_code(sel_idx);
  end

  assign key_release = 1'b0;
`endif

  // Debounced matrix and press mask; a release never cancels a press still pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable  <= '0;
      pending <= '0;
    end else begin
      pending <= (pending & ~press_clr) | new_press;
      if (accept) stable <= raw;
    end
  end

  // Sticky drop flag: push into a full queue with no pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)                                   overflow <= 1'b0;
    else if (push && fifo_full && !key_ready)  overflow <= 1'b1;
  end

  keypad_event_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (key_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  assign key_valid = ~fifo_empty;
  assign key_code  = fifo_empty ? 4'd0 : head[3:0];
  assign key_held  = stable;

endmodule

// File: tb/tb_keypad_key_decoder.sv
// tb_keypad_key_decoder: directed plus random keypad stimulus against a sample-level event model.
// The model works per matrix sample: last DEBOUNCE_CNT samples identical -> new presses/releases,
// emitted in index order into a bounded queue that drops when full and the consumer is stalled.
module tb_keypad_key_decoder;

  localparam int SDIV  = 4;
  localparam int DB    = 3;
  localparam int DEPTH = 4;
`ifdef KEYPAD_RELEASE_EVENT_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row0, row1, row2, row3;
  logic        key_valid;
  logic        key_ready;
  logic [3:0]  key_code;
  logic        key_release;
  logic [15:0] key_held;
  logic        overflow;

  always #5 clk = ~clk;

  keypad_key_decoder #(
    .SAMPLE_DIV   (SDIV),
    .DEBOUNCE_CNT (DB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .row0        (row0),
    .row1        (row1),
    .row2        (row2),
    .row3        (row3),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_code    (key_code),
    .key_release (key_release),
    .key_held    (key_held),
    .overflow    (overflow)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int since_strobe = 0;

  string      LAYOUT = "123A456B789C*0#D";
  logic [4:0] gotq[$];
  logic [4:0] expq[$];
  logic [4:0] mfifo[$];
  logic [15:0] hist[$];
  logic [15:0] m_stable;
  logic        m_ovf;

  // Capture every accepted handshake as {release, code}.
  always @(negedge clk) begin
    if (!rst && key_valid && key_ready) gotq.push_back({key_release, key_code});
  end

  function automatic logic [3:0] code_of(input int idx);
    logic [7:0] ch;
    ch = LAYOUT[idx];
    if (ch >= 8'd48 && ch <= 8'd57) return 4'(ch - 8'd48);  // '0'..'9'
    if (ch >= 8'd65 && ch <= 8'd68) return 4'(ch - 8'd55);  // 'A'..'D'
    if (ch == 8'd42) return 4'd14;                          // '*'
    return 4'd15;                                           // '#'
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_flush();
    if (key_ready) while (mfifo.size() > 0) expq.push_back(mfifo.pop_front());
  endtask

  task automatic model_push(input logic [4:0] ev);
    if (!key_ready && mfifo.size() >= DEPTH) m_ovf = 1'b1;
    else mfifo.push_back(ev);
    model_flush();
  endtask

  task automatic model_reset();
    hist.delete();
    mfifo.delete();
    expq.delete();
    gotq.delete();
    m_stable = 16'h0;
    m_ovf    = 1'b0;
  endtask

  // Drive a matrix snapshot through the next sample strobe, then update the model.
  task automatic sample(input logic [15:0] r);
    logic all_eq;
    {row3, row2, row1, row0} = r;
    repeat (SDIV - since_strobe) @(posedge clk);
    #1;
    since_strobe = 0;
    hist.push_back(r);
    if (hist.size() > DB) void'(hist.pop_front());
    all_eq = (hist.size() == DB);
    foreach (hist[i]) if (hist[i] != r) all_eq = 1'b0;
    if (all_eq) begin
      for (int i = 0; i < 16; i++) if (r[i] && !m_stable[i]) model_push({1'b0, code_of(i)});
      if (REL_EN) for (int i = 0; i < 16; i++) if (!r[i] && m_stable[i]) model_push({1'b1, code_of(i)});
      m_stable = r;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
    since_strobe += n;
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_count"}, gotq.size(), expq.size());
    for (int i = 0; i < gotq.size() && i < expq.size(); i++)
      check($sformatf("%s_ev%0d", tag, i), gotq[i], expq[i]);
    gotq.delete();
    expq.delete();
  endtask

  task automatic repeat_sample(input logic [15:0] r, input int n);
    for (int k = 0; k < n; k++) sample(r);
  endtask

  initial begin
    rst = 1'b1;
    {row3, row2, row1, row0} = 16'h0;
    key_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",    key_valid,   1'b0);
    check("rst_code",     key_code,    4'd0);
    check("rst_release",  key_release, 1'b0);
    check("rst_held",     key_held,    16'h0);
    check("rst_overflow", overflow,    1'b0);
    rst = 1'b0;
    since_strobe = 0;

    // Key '5' held: accept on the third sample, event two cycles later.
    repeat_sample(16'h0020, 3);
    check("t1_held_s1",  key_held,  16'h0020);
    check("t1_valid_s1", key_valid, 1'b0);
    step(1);
    check("t1_valid_s2", key_valid, 1'b1);
    check("t1_code_s2",  key_code,  4'd5);
    repeat_sample(16'h0020, 10);
    compare_stream("t1");

    // Bounce on key '1' produces nothing, then a clean press does.
    repeat_sample(16'h0000, 3);
    for (int k = 0; k < 8; k++) sample((k % 2 == 0) ? 16'h0001 : 16'h0000);
    check("t2_bounce_held", key_held, 16'h0);
    repeat_sample(16'h0001, 3);
    check("t2_held", key_held, 16'h0001);
    repeat_sample(16'h0000, 4);
    compare_stream("t2");

    // Three keys in one accept: codes 1, 10, 0 on consecutive cycles.
    repeat_sample(16'h2009, 3);
    step(1);
    check("t3_code0", key_code, 4'd1);
    step(1);
    check("t3_code1", key_code, 4'd10);
    step(1);
    check("t3_code2", key_code, 4'd0);
    check("t3_valid2", key_valid, 1'b1);
    repeat_sample(16'h0000, 5);
    compare_stream("t3");

    // Stalled consumer, six presses: four queued, overflow, head held steady.
    key_ready = 1'b0;
    repeat_sample(16'h003F, 3);
    step(1);
    check("t4_code_first", key_code, 4'd1);
    repeat_sample(16'h003F, 2);
    check("t4_overflow",     overflow,  1'b1);
    check("t4_model_ovf",    overflow,  m_ovf);
    check("t4_valid_stall",  key_valid, 1'b1);
    check("t4_code_stable",  key_code,  4'd1);
    key_ready = 1'b1;
    model_flush();
    sample(16'h003F);
    check("t4_drained_valid", key_valid, 1'b0);
    compare_stream("t4");

    // Reset with two events queued discards everything.
    repeat_sample(16'h0000, 5);
    compare_stream("t5_pre");
    key_ready = 1'b0;
    repeat_sample(16'h0300, 4);
    check("t5_valid_before", key_valid, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_valid_after",    key_valid, 1'b0);
    check("t5_overflow_after", overflow,  1'b0);
    check("t5_held_after",     key_held,  16'h0);
    rst = 1'b0;
    since_strobe = 0;
    model_reset();
    key_ready = 1'b1;

    // '#' press then release.
    repeat_sample(16'h0000, 3);
    repeat_sample(16'h4000, 3);
    check("t6_held", key_held, 16'h4000);
    repeat_sample(16'h0000, 4);
    check("t6_count_spec", expq.size(), REL_EN ? 2 : 1);
    compare_stream("t6");

    // Random patterns of up to three keys with random hold lengths.
    for (int it = 0; it < 40; it++) begin
      logic [15:0] pat;
      int nb;
      int hold;
      pat = 16'h0;
      if ($urandom_range(0, 3) != 0) begin
        nb = $urandom_range(1, 3);
        for (int b = 0; b < nb; b++) pat[$urandom_range(0, 15)] = 1'b1;
      end
      hold = $urandom_range(1, 5);
      repeat_sample(pat, hold);
      check($sformatf("rand_held_%0d", it), key_held, m_stable);
    end
    repeat_sample(16'h0000, 5);
    check("rand_overflow", overflow, m_ovf);
    compare_stream("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
